// File: rtl/multiplier_pkg.sv
// Shared types for the shift-add multiplier controller.
// State encoding is shared by the controller and any debug tooling.
package multiplier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ADD,
    SHIFT,
    DONE
  } mult_state_t;

  localparam int MULT_N_DEFAULT = 4;

endpackage

// File: rtl/multiplier_counter.sv
// Iteration counter for the multiplier controller.
// Preset to N-1 on LOAD, counts down once per non-final SHIFT.
module multiplier_counter #(
  parameter int N = 4
) (
  input  logic clock,
  input  logic n_reset,
  input  logic do_preset,
  input  logic do_decrement,
  output logic is_zero
);

  localparam int CW = $clog2(N);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (do_preset)
      count_d = CW'(N - 1);
    else if (do_decrement)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign is_zero = (count_q == '0);

  a_no_underflow: assert property (
    @(posedge clock) disable iff (!n_reset)
    !(do_decrement && is_zero));

  a_no_overlap: assert property (
    @(posedge clock) disable iff (!n_reset)
    !(do_preset && do_decrement));

endmodule

// File: rtl/multiplier_controller.sv
// Sequencing FSM for the shift-add multiplier datapath.
// Drives load/add/shift strobes for N iterations, then holds done until ack.
module multiplier_controller
  import multiplier_pkg::*;
#(
  parameter int N = MULT_N_DEFAULT
) (
  input  logic clock,
  input  logic n_reset,
  input  logic start,
  input  logic abort,
  input  logic ack,
  input  logic multiplier_lsb,
  output logic ready,
  output logic done,
  output logic do_load,
  output logic do_add,
  output logic do_shift
);

  mult_state_t state_q;
  mult_state_t state_d;
  logic        is_zero;
  logic        do_preset;
  logic        do_decrement;

  assign do_preset    = (state_q == LOAD);
  assign do_decrement = (state_q == SHIFT) && !is_zero;

  multiplier_counter #(
    .N(N)
  ) u_counter (
    .clock       (clock),
    .n_reset     (n_reset),
    .do_preset   (do_preset),
    .do_decrement(do_decrement),
    .is_zero     (is_zero)
  );

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    done     = 1'b0;
    do_load  = 1'b0;
    do_add   = 1'b0;
    do_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (start)
          state_d = LOAD;
      end
      LOAD: begin
        do_load = 1'b1;
        state_d = abort ? IDLE : ADD;
      end
      ADD: begin
        // ADD is spent even when lsb=0 to keep latency fixed
        do_add  = multiplier_lsb;
        state_d = abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (abort)
          state_d = IDLE;
        else
          state_d = is_zero ? DONE : ADD;
      end
      DONE: begin
        done = 1'b1;
        if (abort)
          state_d = IDLE;
        else if (ack)
          state_d = start ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  a_strobe_onehot: assert property (
    @(posedge clock) disable iff (!n_reset)
    $onehot0({do_load, do_add, do_shift}));

endmodule
